// File: rtl/dm_cache_ctrl_pkg.sv
// Shared parameters and types for the direct-mapped cache controller slice.
// Holds the field widths, the FSM state set and the CPU address split.
package memory_sub_system_param;

    localparam int TAG_LENGTH      = 8;
    localparam int INDEX_LENGTH    = 4;
    localparam int OFFSET_LENGTH   = 4;
    localparam int NUM_CACHE_LINES = 2 ** INDEX_LENGTH;
    localparam int ADDR_LENGTH     = TAG_LENGTH + INDEX_LENGTH + OFFSET_LENGTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, UPDATE, RESP} cache_state_t;

    typedef struct packed {
        logic [TAG_LENGTH-1:0]    tag;
        logic [INDEX_LENGTH-1:0]  index;
        logic [OFFSET_LENGTH-1:0] offset;
    } cache_addr_t;

    // Refills always fetch a whole line, so the byte offset is forced to zero.
    function automatic logic [ADDR_LENGTH-1:0] line_addr(input logic [TAG_LENGTH-1:0] tag,
                                                         input logic [INDEX_LENGTH-1:0] index);
        return {tag, index, {OFFSET_LENGTH{1'b0}}};
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU / tag RAM / main-memory signal bundle of the cache controller.
// master = controller side, slave = the CPU, RAMs and memory around it.
interface dm_cache_ctrl_if;
    import memory_sub_system_param::*;

    logic                     cpu_req_valid;
    logic                     cpu_req_ready;
    logic [ADDR_LENGTH-1:0]   cpu_addr;
    logic                     cpu_flush;
    logic                     cpu_resp_valid;
    logic                     cpu_hit;
    logic                     tag_write;
    logic [INDEX_LENGTH-1:0]  tag_index;
    logic [TAG_LENGTH-1:0]    tag_wdata;
    logic [TAG_LENGTH-1:0]    tag_rdata;
    logic                     mem_req;
    logic [ADDR_LENGTH-1:0]   mem_addr;
    logic                     mem_ack;
    logic                     data_we;

    modport master (
        input  cpu_req_valid, cpu_addr, cpu_flush, tag_rdata, mem_ack,
        output cpu_req_ready, cpu_resp_valid, cpu_hit, tag_write, tag_index,
               tag_wdata, mem_req, mem_addr, data_we
    );

    modport slave (
        output cpu_req_valid, cpu_addr, cpu_flush, tag_rdata, mem_ack,
        input  cpu_req_ready, cpu_resp_valid, cpu_hit, tag_write, tag_index,
               tag_wdata, mem_req, mem_addr, data_we
    );

endinterface

// File: rtl/dm_cache_ctrl_valid_array.sv
// Per-line valid bits: single-line set, whole-array clear, combinational read.
module dm_valid_array
    import memory_sub_system_param::*;
#(
    parameter int NUM_L = NUM_CACHE_LINES,
    parameter int IDX_W = INDEX_LENGTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clear_all,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid
);

    logic [NUM_L-1:0] valid;

    always_ff @(posedge clk) begin
        if (!resetn || clear_all) begin
            valid <= '0;
        end else if (set_en) begin
            valid[set_idx] <= 1'b1;
        end
    end

    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Lookup/refill controller of the direct-mapped cache.
// Optional DM_CACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module dm_cache_ctrl
    import memory_sub_system_param::*;
(
    input  logic              clk,
    input  logic              resetn,
    dm_cache_ctrl_if.master   bus
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_LOOKUP = LOOKUP;
    localparam logic [2:0] ST_REFILL = REFILL;
    localparam logic [2:0] ST_UPDATE = UPDATE;
    localparam logic [2:0] ST_RESP   = RESP;

    logic [2:0]              state;
    logic [TAG_LENGTH-1:0]   tag_q;
    logic [INDEX_LENGTH-1:0] idx_q;
    logic                    hit_q;
    logic                    line_valid;
    logic                    lookup_hit;
    logic                    flush_acc;
    logic                    accept;
    cache_addr_t             cpu_a;
    logic                    unused_offset;

    assign cpu_a         = bus.cpu_addr;
    assign unused_offset = ^cpu_a.offset;

    // Flush takes priority over a request presented in the same IDLE cycle.
    assign flush_acc         = resetn && (state == ST_IDLE) && bus.cpu_flush;
    assign bus.cpu_req_ready = resetn && (state == ST_IDLE) && !bus.cpu_flush;
    assign accept            = bus.cpu_req_valid && bus.cpu_req_ready;
    assign lookup_hit        = line_valid && (bus.tag_rdata == tag_q);

    dm_valid_array #(
        .NUM_L (NUM_CACHE_LINES),
        .IDX_W (INDEX_LENGTH)
    ) u_valid (
        .clk       (clk),
        .resetn    (resetn),
        .set_en    (state == ST_UPDATE),
        .set_idx   (idx_q),
        .clear_all (flush_acc),
        .rd_idx    (idx_q),
        .rd_valid  (line_valid)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept) state <= ST_LOOKUP;
                ST_LOOKUP: state <= lookup_hit ? ST_RESP : ST_REFILL;
                ST_REFILL: if (bus.mem_ack) state <= ST_UPDATE;
                ST_UPDATE: state <= ST_RESP;
                ST_RESP:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q <= cpu_a.tag;
            idx_q <= cpu_a.index;
        end
        if (state == ST_LOOKUP) hit_q <= lookup_hit;
    end

    // In IDLE the index follows the CPU address so the tag RAM reads on the accept edge.
    always_comb begin
        bus.tag_index = '0;
        if (resetn) bus.tag_index = (state == ST_IDLE) ? cpu_a.index : idx_q;
    end

    assign bus.tag_write      = (state == ST_UPDATE);
    assign bus.tag_wdata      = (state == ST_UPDATE) ? tag_q : '0;
    assign bus.data_we        = (state == ST_UPDATE);
    assign bus.mem_req        = (state == ST_REFILL);
    assign bus.mem_addr       = (state == ST_REFILL) ? line_addr(tag_q, idx_q) : '0;
    assign bus.cpu_resp_valid = (state == ST_RESP);
    assign bus.cpu_hit        = (state == ST_RESP) && hit_q;

`ifdef DM_CACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn || flush_acc) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == ST_LOOKUP) begin
            if (lookup_hit) hit_count  <= sat_inc(hit_count);
            else            miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: tag RAM model plus a line-state reference model.
module tb_dm_cache_ctrl;
    import memory_sub_system_param::*;

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    dm_cache_ctrl_if bus();

`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dm_cache_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
`ifdef DM_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read tag RAM
    logic [TAG_LENGTH-1:0] tag_mem [NUM_CACHE_LINES];
    initial for (int i = 0; i < NUM_CACHE_LINES; i++) tag_mem[i] = '0;
    always @(posedge clk) begin
        if (bus.tag_write) tag_mem[bus.tag_index] <= bus.tag_wdata;
        bus.tag_rdata <= tag_mem[bus.tag_index];
    end

    // Reference model: what each line holds, and the resulting event counts
    logic [NUM_CACHE_LINES-1:0] valid_ref;
    logic [TAG_LENGTH-1:0]      tag_ref [NUM_CACHE_LINES];
    int hits_ref, miss_ref;

    function automatic void model_clear();
        valid_ref = '0;
        hits_ref  = 0;
        miss_ref  = 0;
    endfunction

    // Expected {hit, resp cycle after accept, mem_req cycles, tag writes, violations}
    function automatic logic [39:0] exp_read(input logic [ADDR_LENGTH-1:0] a, input int d);
        cache_addr_t ca;
        ca = a;
        if (valid_ref[ca.index] && tag_ref[ca.index] == ca.tag) begin
            hits_ref++;
            return {8'd1, 8'd2, 8'd0, 8'd0, 8'd0};
        end
        miss_ref++;
        valid_ref[ca.index] = 1'b1;
        tag_ref[ca.index]   = ca.tag;
        return {8'd0, 8'(4 + d), 8'(d + 1), 8'd1, 8'd0};
    endfunction

    // Issues one read from a negedge; acks the refill after d extra wait cycles.
    task automatic do_read(input logic [ADDR_LENGTH-1:0] a, input int d, input bit noise,
                           output logic [39:0] obs, output int wait_cyc);
        cache_addr_t ca;
        logic [ADDR_LENGTH-1:0] line;
        logic h;
        int cyc, lat, nreq, ntw, bad;
        ca = a;
        line = a;
        line[OFFSET_LENGTH-1:0] = '0;
        h = 1'bx; lat = 0; nreq = 0; ntw = 0; bad = 0; wait_cyc = 0;
        bus.cpu_addr = a;
        bus.cpu_req_valid = 1'b1;
        #1;
        while (!bus.cpu_req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
            #1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        bus.cpu_addr = ADDR_LENGTH'($urandom);
        cyc = 1;
        while (cyc < 60) begin
            if (bus.cpu_resp_valid) begin
                lat = cyc;
                h = bus.cpu_hit;
                break;
            end
            if (bus.mem_req) begin
                nreq++;
                if (bus.mem_addr !== line) bad++;
                bus.mem_ack = (nreq == d + 1);
            end else begin
                bus.mem_ack = noise;
            end
            if (bus.data_we !== bus.tag_write) bad++;
            if (bus.tag_write) begin
                ntw++;
                if (bus.tag_index !== ca.index || bus.tag_wdata !== ca.tag) bad++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.mem_ack = 1'b0;
        obs = {8'(h), 8'(lat), 8'(nreq), 8'(ntw), 8'(bad)};
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr = 16'hABCD;
        bus.cpu_flush = 1'b0;
        bus.mem_ack = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cpu_req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", bus.cpu_req_ready);
        end
        checks++;
        if ({bus.cpu_resp_valid, bus.cpu_hit, bus.tag_write, bus.data_we, bus.mem_req} !== 5'b0
            || bus.tag_index !== '0 || bus.tag_wdata !== '0 || bus.mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got resp=%b hit=%b tw=%b we=%b req=%b idx=%h wd=%h ma=%h want all 0",
                     bus.cpu_resp_valid, bus.cpu_hit, bus.tag_write, bus.data_we, bus.mem_req,
                     bus.tag_index, bus.tag_wdata, bus.mem_addr);
        end
        resetn = 1'b1;
        bus.cpu_req_valid = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        checks++;
        if (bus.cpu_req_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready: got %b want 1", bus.cpu_req_ready);
        end
    endtask

    task automatic test_cold_and_hit();
        logic [39:0] obs, exp;
        int w;
        exp = exp_read(16'h5A37, 2);
        do_read(16'h5A37, 2, 1'b0, obs, w);
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL cold_miss: got %h want %h (hit/lat/req/tw/bad)", obs, exp);
        end
        exp = exp_read(16'h5A3C, 0);
        do_read(16'h5A3C, 0, 1'b1, obs, w);
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL repeat_hit: got %h want %h (hit/lat/req/tw/bad)", obs, exp);
        end
    endtask

    task automatic test_conflict();
        logic [39:0] obs, exp;
        logic [ADDR_LENGTH-1:0] seq [3];
        int w;
        seq = '{16'hC331, 16'h5A37, 16'h5A30};
        foreach (seq[i]) begin
            exp = exp_read(seq[i], 1);
            do_read(seq[i], 1, 1'b0, obs, w);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL conflict[%0d]: got %h want %h (hit/lat/req/tw/bad)", i, obs, exp);
            end
        end
    endtask

    task automatic test_index_edges();
        logic [39:0] obs, exp;
        logic [ADDR_LENGTH-1:0] a;
        cache_addr_t ca;
        int w;
        for (int k = 0; k < 2; k++) begin
            ca.tag = TAG_LENGTH'($urandom);
            ca.index = (k == 0) ? '0 : INDEX_LENGTH'(NUM_CACHE_LINES - 1);
            ca.offset = OFFSET_LENGTH'($urandom_range(1, 15));
            a = ca;
            exp = exp_read(a, 5);
            do_read(a, 5, 1'b0, obs, w);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL edge_miss[%0d]: got %h want %h (hit/lat/req/tw/bad)", k, obs, exp);
            end
            exp = exp_read(a, 0);
            do_read(a, 0, 1'b0, obs, w);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL edge_hit[%0d]: got %h want %h (hit/lat/req/tw/bad)", k, obs, exp);
            end
        end
    endtask

    task automatic test_flush();
        logic [39:0] obs, exp;
        int w;
        @(negedge clk);
        bus.cpu_flush = 1'b1;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr = 16'h5A37;
        #1;
        checks++;
        if (bus.cpu_req_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b want 0", bus.cpu_req_ready);
        end
        @(negedge clk);
        bus.cpu_flush = 1'b0;
        bus.cpu_req_valid = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.cpu_req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_not_accepted: got ready=%b req=%b want ready=1 req=0",
                               bus.cpu_req_ready, bus.mem_req);
        end
        exp = exp_read(16'h5A37, 0);
        do_read(16'h5A37, 0, 1'b0, obs, w);
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL after_flush: got %h want %h (hit/lat/req/tw/bad)", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] obs, exp;
        logic [ADDR_LENGTH-1:0] a;
        int w;
        for (int i = 0; i < 6; i++) begin
            a = {8'h5A, 4'h3, 4'(i)};
            if (i % 2 == 1) a = {8'h77, 4'(i), 4'h0};
            exp = exp_read(a, 0);
            do_read(a, 0, 1'b0, obs, w);
            checks++;
            if (obs !== exp || w != 1) begin
                errors++; $display("FAIL back_to_back[%0d]: got %h wait=%0d want %h wait=1", i, obs, w, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [39:0] obs, exp;
        logic [ADDR_LENGTH-1:0] a;
        logic [TAG_LENGTH-1:0] tags [3];
        int d, w;
        tags = '{8'h11, 8'h22, 8'h00};
        for (int i = 0; i < 40; i++) begin
            a = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 15)), 4'($urandom)};
            d = $urandom_range(0, 3);
            exp = exp_read(a, d);
            do_read(a, d, 1'($urandom), obs, w);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL random[%0d] addr=%h: got %h want %h (hit/lat/req/tw/bad)", i, a, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [39:0] obs, exp;
        int w;
        @(negedge clk);
        bus.cpu_addr = 16'hA539;
        bus.cpu_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++; $display("FAIL refill_req: got %b want 1", bus.mem_req);
        end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || bus.cpu_req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_refill: got req=%b ready=%b want 0/0", bus.mem_req, bus.cpu_req_ready);
        end
        resetn = 1'b1;
        model_clear();
        exp = exp_read(16'h5A37, 1);
        do_read(16'h5A37, 1, 1'b0, obs, w);
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL post_reset_read: got %h want %h (hit/lat/req/tw/bad)", obs, exp);
        end
    endtask

`ifdef DM_CACHE_STATS_EN
    task automatic test_stats();
        checks++;
        if (hit_count !== 32'(hits_ref) || miss_count !== 32'(miss_ref)) begin
            errors++; $display("FAIL stats: got hit=%0d miss=%0d want hit=%0d miss=%0d",
                               hit_count, miss_count, hits_ref, miss_ref);
        end
    endtask
`endif

    initial begin
        bus.cpu_req_valid = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_flush = 1'b0;
        bus.mem_ack = 1'b0;
        resetn = 1'b0;
        test_reset();
        test_cold_and_hit();
        test_conflict();
        test_index_edges();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid_refill();
`ifdef DM_CACHE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
